// File: rtl/clock_set_ctrl.sv
// Time-setting controller: debounced keys drive a RUN/SET_H/SET_M/SET_S/COMMIT FSM that edits and commits time.
// Latency: raw key edge to press pulse DEB_CYC+2 cycles; FSM and outputs react on the following edge.
// No backpressure: WR is a single-cycle strobe that the clock core must accept unconditionally.
module clock_set_ctrl #(
   parameter int DEB_CYC     = 16,
   parameter int TIMEOUT_CYC = 1024,
   parameter int BLINK_HALF  = 256
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       KEY_MODE,
   input  logic       KEY_INC,
   input  logic       KEY_DEC,
   input  logic [4:0] H_cur,
   input  logic [5:0] M_cur,
   input  logic [5:0] S_cur,
   output logic       LOAD,
   output logic       WR,
   output logic [4:0] H_set,
   output logic [5:0] M_set,
   output logic [5:0] S_set,
   output logic [2:0] SEL,
   output logic       BLINK
);

   localparam int DW = $clog2(DEB_CYC);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam int BW = $clog2(BLINK_HALF + 1);

   typedef enum logic [2:0] {RUN, SET_H, SET_M, SET_S, COMMIT} state_t;

   // key index: 2 = mode, 1 = inc, 0 = dec
   logic [2:0]    key_raw;
   logic [2:0]    sync_0, sync_1;
   logic [2:0]    key_lvl, key_prs;
   logic [DW-1:0] deb_cnt [3];
   state_t        state, state_nxt;
   logic [TW-1:0] tmo_cnt;
   logic [BW-1:0] blk_cnt;
   logic          p_mode, p_inc, p_dec, any_press;
   logic          in_set, nxt_set, tmo_hit;

   assign key_raw   = {KEY_MODE, KEY_INC, KEY_DEC};
   assign p_mode    = key_prs[2];
   assign p_inc     = key_prs[1];
   assign p_dec     = key_prs[0];
   assign any_press = |key_prs;
   assign in_set    = (state == SET_H) || (state == SET_M) || (state == SET_S);
   assign nxt_set   = (state_nxt == SET_H) || (state_nxt == SET_M) || (state_nxt == SET_S);
   assign tmo_hit   = (tmo_cnt == TW'(TIMEOUT_CYC - 1));

   // Wrapping +/-1 on a field whose legal range is 0..mx.
   function automatic logic [5:0] step(input logic [5:0] v, input logic [5:0] mx, input logic up);
      if (up)
         return (v >= mx) ? 6'd0 : v + 6'd1;
      return (v == 6'd0 || v > mx) ? mx : v - 6'd1;
   endfunction

   // Two-flop synchronizer for the asynchronous raw keys.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         sync_0 <= '0;
         sync_1 <= '0;
      end else begin
         sync_0 <= key_raw;
         sync_1 <= sync_0;
      end
   end

   // Debounce: accept a new level after DEB_CYC equal differing samples; pulse only on acceptance of a 1.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         key_lvl <= '0;
         key_prs <= '0;
         for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            key_prs[i] <= 1'b0;
            if (sync_1[i] != key_lvl[i]) begin
               if (deb_cnt[i] == DW'(DEB_CYC - 1)) begin
                  key_lvl[i] <= sync_1[i];
                  key_prs[i] <= sync_1[i];
                  deb_cnt[i] <= '0;
               end else begin
                  deb_cnt[i] <= deb_cnt[i] + 1'b1;
               end
            end else begin
               deb_cnt[i] <= '0;
            end
         end
      end
   end

   // Next-state decode; a key press in the timeout cycle counts as activity and blocks the auto-commit.
   always_comb begin
      state_nxt = state;
      case (state)
         RUN:     if (p_mode) state_nxt = SET_H;
         SET_H:   if (p_mode) state_nxt = SET_M;
                  else if (tmo_hit && !any_press) state_nxt = COMMIT;
         SET_M:   if (p_mode) state_nxt = SET_S;
                  else if (tmo_hit && !any_press) state_nxt = COMMIT;
         SET_S:   if (p_mode) state_nxt = COMMIT;
                  else if (tmo_hit && !any_press) state_nxt = COMMIT;
         COMMIT:  state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
   end

   // FSM state, registered outputs, field editing, timeout and blink counters.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state   <= RUN;
         LOAD    <= 1'b0;
         WR      <= 1'b0;
         SEL     <= 3'b000;
         BLINK   <= 1'b0;
         H_set   <= '0;
         M_set   <= '0;
         S_set   <= '0;
         tmo_cnt <= '0;
         blk_cnt <= '0;
      end else begin
         state <= state_nxt;
         LOAD  <= (state_nxt != RUN);
         WR    <= (state_nxt == COMMIT);
         case (state_nxt)
            SET_H:   SEL <= 3'b100;
            SET_M:   SEL <= 3'b010;
            SET_S:   SEL <= 3'b001;
            default: SEL <= 3'b000;
         endcase

         // Capture the live time on entry; edits use the field selected before any MODE transition.
         if (state == RUN && p_mode) begin
            H_set <= H_cur;
            M_set <= M_cur;
            S_set <= S_cur;
         end else if (in_set && (p_inc ^ p_dec)) begin
            case (state)
               SET_H:   H_set <= 5'(step({1'b0, H_set}, 6'd23, p_inc));
               SET_M:   M_set <= step(M_set, 6'd59, p_inc);
               SET_S:   S_set <= step(S_set, 6'd59, p_inc);
               default: ;
            endcase
         end

         if (nxt_set && state_nxt == state && !any_press) begin
            if (!tmo_hit) tmo_cnt <= tmo_cnt + 1'b1;
         end else begin
            tmo_cnt <= '0;
         end

         if (nxt_set) begin
            if (state_nxt != state) begin
               blk_cnt <= '0;
               BLINK   <= 1'b1;
            end else if (blk_cnt == BW'(BLINK_HALF - 1)) begin
               blk_cnt <= '0;
               BLINK   <= ~BLINK;
            end else begin
               blk_cnt <= blk_cnt + 1'b1;
            end
         end else begin
            blk_cnt <= '0;
            BLINK   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: scenario tasks with inline checks plus a commit scoreboard.
// Expected commit values are queued when the committing stimulus is driven and popped on WR.
// Inputs driven #1 after the rising edge; outputs sampled there or on the falling edge.
module tb_clock_set_ctrl;
   localparam int DEB = 4;
   localparam int TMO = 64;
   localparam int BH  = 8;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       KEY_MODE = 1'b0, KEY_INC = 1'b0, KEY_DEC = 1'b0;
   logic [4:0] H_cur = '0;
   logic [5:0] M_cur = '0, S_cur = '0;
   logic       LOAD, WR, BLINK;
   logic [4:0] H_set;
   logic [5:0] M_set, S_set;
   logic [2:0] SEL;

   int chk_cnt = 0;
   int pass_cnt = 0;
   int wr_cnt = 0;
   logic [16:0] exp_q[$];
   logic [16:0] mon_exp;

   clock_set_ctrl #(.DEB_CYC(DEB), .TIMEOUT_CYC(TMO), .BLINK_HALF(BH)) dut (
      .CLK(CLK), .RST(RST), .KEY_MODE(KEY_MODE), .KEY_INC(KEY_INC), .KEY_DEC(KEY_DEC),
      .H_cur(H_cur), .M_cur(M_cur), .S_cur(S_cur), .LOAD(LOAD), .WR(WR),
      .H_set(H_set), .M_set(M_set), .S_set(S_set), .SEL(SEL), .BLINK(BLINK)
   );

   always #5 CLK = ~CLK;

   // Scoreboard: every WR pulse must match the oldest queued commit.
   always @(negedge CLK) begin
      if (RST && WR) begin
         wr_cnt++;
         chk_cnt++;
         if (exp_q.size() == 0) begin
            $display("FAIL wr_unexpected got H=%0d M=%0d S=%0d, no commit expected", H_set, M_set, S_set);
         end else begin
            mon_exp = exp_q.pop_front();
            if ({H_set, M_set, S_set} !== mon_exp)
               $display("FAIL wr_data got %0d/%0d/%0d want %0d/%0d/%0d", H_set, M_set, S_set,
                        mon_exp[16:12], mon_exp[11:6], mon_exp[5:0]);
            else
               pass_cnt++;
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic do_reset;
      RST = 1'b0;
      KEY_MODE = 1'b0; KEY_INC = 1'b0; KEY_DEC = 1'b0;
      tick(3);
      RST = 1'b1;
      tick(2);
   endtask

   // k: 2 = mode, 1 = inc, 0 = dec, 3 = inc and dec together
   task automatic press(input int k, input int hold);
      KEY_MODE = (k == 2);
      KEY_INC  = (k == 1) || (k == 3);
      KEY_DEC  = (k == 0) || (k == 3);
      tick(hold);
      KEY_MODE = 1'b0; KEY_INC = 1'b0; KEY_DEC = 1'b0;
      tick(DEB + 6);
   endtask

   // Final MODE press from SET_S, expecting a one-cycle WR with the given fields.
   task automatic commit_mode(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
      bit found;
      found = 1'b0;
      exp_q.push_back({h, m, s});
      KEY_MODE = 1'b1;
      for (int i = 0; i < 15; i++) begin
         tick(1);
         if (WR === 1'b1) begin found = 1'b1; break; end
      end
      chk_cnt++;
      if (!found) $display("FAIL commit_wr got no WR want WR within 15 cycles");
      else pass_cnt++;
      tick(1);
      chk_cnt++;
      if ({WR, LOAD, SEL, BLINK} !== 6'b0)
         $display("FAIL commit_run got WR=%b LOAD=%b SEL=%b BLINK=%b want all 0", WR, LOAD, SEL, BLINK);
      else pass_cnt++;
      KEY_MODE = 1'b0;
      tick(10);
   endtask

   task automatic test_reset;
      bit found;
      #2 RST = 1'b0;
      tick(2);
      chk_cnt++;
      if ({LOAD, WR, SEL, BLINK, H_set, M_set, S_set} !== 23'd0)
         $display("FAIL reset_vals got %b want 0", {LOAD, WR, SEL, BLINK, H_set, M_set, S_set});
      else pass_cnt++;
      RST = 1'b1;
      tick(2);
      KEY_MODE = 1'b1; tick(3); KEY_MODE = 1'b0; tick(15);
      chk_cnt++;
      if (LOAD !== 1'b0 || SEL !== 3'b000) $display("FAIL glitch got LOAD=%b SEL=%b want 0/000", LOAD, SEL);
      else pass_cnt++;
      H_cur = 5'd12; M_cur = 6'd34; S_cur = 6'd56;
      KEY_MODE = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         if (LOAD === 1'b1) begin found = 1'b1; break; end
      end
      chk_cnt++;
      if (!found) $display("FAIL enter_set_h got LOAD=0 want LOAD=1 within 10 cycles");
      else pass_cnt++;
      chk_cnt++;
      if (SEL !== 3'b100 || H_set !== 5'd12 || M_set !== 6'd34 || S_set !== 6'd56 || BLINK !== 1'b1)
         $display("FAIL entry_state got SEL=%b %0d/%0d/%0d BLINK=%b want 100 12/34/56 1", SEL, H_set, M_set, S_set, BLINK);
      else pass_cnt++;
      tick(BH - 1);
      chk_cnt++;
      if (BLINK !== 1'b1) $display("FAIL blink_hold got %b want 1", BLINK);
      else pass_cnt++;
      tick(1);
      chk_cnt++;
      if (BLINK !== 1'b0) $display("FAIL blink_toggle got %b want 0", BLINK);
      else pass_cnt++;
      KEY_MODE = 1'b0;
      tick(10);
   endtask

   task automatic test_wrap;
      do_reset;
      H_cur = 5'd23; M_cur = 6'd0; S_cur = 6'd5;
      press(2, 8);
      chk_cnt++;
      if (SEL !== 3'b100 || H_set !== 5'd23) $display("FAIL wrap_entry got SEL=%b H=%0d want 100 23", SEL, H_set);
      else pass_cnt++;
      press(1, 8);
      chk_cnt++;
      if (H_set !== 5'd0) $display("FAIL h_inc_wrap got %0d want 0", H_set);
      else pass_cnt++;
      press(0, 8);
      chk_cnt++;
      if (H_set !== 5'd23) $display("FAIL h_dec_wrap got %0d want 23", H_set);
      else pass_cnt++;
      press(2, 8);
      press(0, 8);
      chk_cnt++;
      if (SEL !== 3'b010 || M_set !== 6'd59) $display("FAIL m_dec_wrap got SEL=%b M=%0d want 010 59", SEL, M_set);
      else pass_cnt++;
      press(2, 8);
      commit_mode(5'd23, 6'd59, 6'd5);
   endtask

   task automatic test_full_seq;
      int wr0;
      do_reset;
      H_cur = 5'd12; M_cur = 6'd34; S_cur = 6'd56;
      press(2, 8); press(2, 8); press(2, 8);
      chk_cnt++;
      if (SEL !== 3'b001 || LOAD !== 1'b1) $display("FAIL set_s_sel got SEL=%b LOAD=%b want 001 1", SEL, LOAD);
      else pass_cnt++;
      press(1, 8);
      chk_cnt++;
      if (S_set !== 6'd57) $display("FAIL s_inc got %0d want 57", S_set);
      else pass_cnt++;
      wr0 = wr_cnt;
      commit_mode(5'd12, 6'd34, 6'd57);
      chk_cnt++;
      if (wr_cnt !== wr0 + 1) $display("FAIL wr_once got %0d pulses want 1", wr_cnt - wr0);
      else pass_cnt++;
      H_cur = 5'd3;
      tick(5);
      chk_cnt++;
      if (H_set !== 5'd12) $display("FAIL run_hold got H=%0d want 12", H_set);
      else pass_cnt++;
   endtask

   task automatic test_timeout;
      bit found;
      int n, wr0;
      do_reset;
      H_cur = 5'd7; M_cur = 6'd8; S_cur = 6'd9;
      press(2, 8);
      KEY_MODE = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 15; i++) begin
         tick(1);
         if (SEL === 3'b010) begin found = 1'b1; break; end
      end
      KEY_MODE = 1'b0;
      chk_cnt++;
      if (!found) $display("FAIL tmo_entry got SEL=%b want 010", SEL);
      else pass_cnt++;
      exp_q.push_back({5'd7, 6'd8, 6'd9});
      found = 1'b0;
      n = 0;
      for (int i = 0; i < 100; i++) begin
         tick(1);
         n++;
         if (WR === 1'b1) begin found = 1'b1; break; end
      end
      chk_cnt++;
      if (!found || n != TMO) $display("FAIL tmo_commit got WR after %0d cycles (seen=%0b) want %0d", n, found, TMO);
      else pass_cnt++;
      tick(1);
      chk_cnt++;
      if (LOAD !== 1'b0 || SEL !== 3'b000) $display("FAIL tmo_run got LOAD=%b SEL=%b want 0 000", LOAD, SEL);
      else pass_cnt++;
      tick(10);
      press(2, 8); press(2, 8);
      wr0 = wr_cnt;
      for (int k = 0; k < 4; k++) begin
         press(1, 6);
         tick(24);
      end
      chk_cnt++;
      if (wr_cnt !== wr0 || SEL !== 3'b010 || M_set !== 6'd12)
         $display("FAIL tmo_keepalive got wr=%0d SEL=%b M=%0d want 0 010 12", wr_cnt - wr0, SEL, M_set);
      else pass_cnt++;
      press(2, 8);
      commit_mode(5'd7, 6'd12, 6'd9);
   endtask

   task automatic test_simul;
      bit found;
      int n;
      do_reset;
      H_cur = 5'd1; M_cur = 6'd2; S_cur = 6'd3;
      press(2, 8); press(2, 8); press(2, 8);
      tick(10);
      exp_q.push_back({5'd1, 6'd2, 6'd3});
      KEY_INC = 1'b1; KEY_DEC = 1'b1;
      found = 1'b0;
      n = 0;
      for (int i = 0; i < 120; i++) begin
         tick(1);
         n++;
         if (n == 8) begin KEY_INC = 1'b0; KEY_DEC = 1'b0; end
         if (n == 20) begin
            chk_cnt++;
            if (S_set !== 6'd3) $display("FAIL incdec_same got S=%0d want 3", S_set);
            else pass_cnt++;
         end
         if (WR === 1'b1) begin found = 1'b1; break; end
      end
      chk_cnt++;
      if (!found || n != DEB + 3 + TMO)
         $display("FAIL incdec_activity got WR after %0d cycles (seen=%0b) want %0d", n, found, DEB + 3 + TMO);
      else pass_cnt++;
      tick(12);
      H_cur = 5'd10; M_cur = 6'd20; S_cur = 6'd30;
      press(2, 8);
      KEY_MODE = 1'b1; KEY_INC = 1'b1;
      tick(8);
      KEY_MODE = 1'b0; KEY_INC = 1'b0;
      tick(10);
      chk_cnt++;
      if (SEL !== 3'b010 || H_set !== 5'd11) $display("FAIL mode_inc got SEL=%b H=%0d want 010 11", SEL, H_set);
      else pass_cnt++;
      press(2, 8);
      commit_mode(5'd11, 6'd20, 6'd30);
   endtask

   task automatic test_reset_mid;
      int wr0;
      do_reset;
      H_cur = 5'd4; M_cur = 6'd5; S_cur = 6'd6;
      press(2, 8); press(2, 8); press(1, 8);
      chk_cnt++;
      if (M_set !== 6'd6) $display("FAIL mid_edit got M=%0d want 6", M_set);
      else pass_cnt++;
      wr0 = wr_cnt;
      @(posedge CLK);
      #3 RST = 1'b0;
      #1;
      chk_cnt++;
      if ({LOAD, WR, SEL, BLINK, H_set, M_set, S_set} !== 23'd0)
         $display("FAIL async_reset got %b want 0", {LOAD, WR, SEL, BLINK, H_set, M_set, S_set});
      else pass_cnt++;
      tick(3);
      RST = 1'b1;
      tick(20);
      chk_cnt++;
      if (wr_cnt !== wr0) $display("FAIL reset_no_wr got %0d pulses want 0", wr_cnt - wr0);
      else pass_cnt++;
      press(2, 8); press(2, 8); press(2, 8);
      exp_q.push_back({5'd4, 6'd5, 6'd7});
      KEY_INC = 1'b1;
      tick(200);
      KEY_INC = 1'b0;
      tick(10);
      chk_cnt++;
      if (S_set !== 6'd7 || wr_cnt !== wr0 + 1 || LOAD !== 1'b0)
         $display("FAIL hold_inc got S=%0d wr=%0d LOAD=%b want 7 1 0", S_set, wr_cnt - wr0, LOAD);
      else pass_cnt++;
   endtask

   initial begin
      test_reset;
      test_wrap;
      test_full_seq;
      test_timeout;
      test_simul;
      test_reset_mid;
      chk_cnt++;
      if (exp_q.size() != 0) $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
      else pass_cnt++;
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
Time-setting controller for the digital clock. It debounces the user keys and runs a mode FSM that freezes the clock and selects the hour, minute or second field. It increments or decrements the selected field with wrap-around, then commits the new time to the clock core. It also drives the LOAD hold signal and the digit-blink indication for the display.

Parameters:
DEB_CYC, 16, number of consecutive stable synchronized samples required before a key change is accepted (>=2)
TIMEOUT_CYC, 1024, number of cycles with no accepted key press in a SET state before an automatic commit
BLINK_HALF, 256, half-period of BLINK in cycles

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  asynchronous, active-low reset
KEY_MODE  in  1  raw mode key, active-high, asynchronous to CLK
KEY_INC  in  1  raw increment key, active-high, asynchronous
KEY_DEC  in  1  raw decrement key, active-high, asynchronous
H_cur  in  5  current hour from the clock core, 0..23
M_cur  in  6  current minute from the clock core, 0..59
S_cur  in  6  current second from the clock core, 0..59
LOAD  out  1  high while any SET state is active; freezes the clock core
WR  out  1  one-cycle commit strobe; H_set/M_set/S_set are valid in the same cycle
H_set  out  5  edited hour
M_set  out  6  edited minute
S_set  out  6  edited second
SEL  out  3  one-hot selected field, {H,M,S}; 000 in RUN
BLINK  out  1  blink phase for the selected digits; 0 in RUN

Behaviour:
- Reset (RST=0, asynchronous): state=RUN; LOAD=0, WR=0, SEL=000, BLINK=0; H_set/M_set/S_set=0; debouncers, timeout counter and blink counter cleared; debounced key levels=0.
- Input path: each key passes through a 2-flop synchronizer, then a debouncer.
  - The debounced level changes only after DEB_CYC consecutive equal synchronized samples that differ from the current level.
  - A press event is a one-cycle pulse on the debounced 0->1 transition; releases generate no event.
  - Latency from a clean raw edge to the press pulse is DEB_CYC+2 cycles.
- FSM states: RUN, SET_H, SET_M, SET_S, COMMIT.
  - RUN --MODE--> SET_H. In the same edge, H_set/M_set/S_set capture H_cur/M_cur/S_cur.
  - SET_H --MODE--> SET_M --MODE--> SET_S --MODE--> COMMIT.
  - Any SET state with the timeout counter reaching TIMEOUT_CYC-1 --> COMMIT.
  - COMMIT --> RUN unconditionally after 1 cycle.
- Outputs per state:
  - LOAD=1 in SET_H, SET_M, SET_S and COMMIT; LOAD=0 in RUN.
  - WR=1 only in COMMIT.
  - SEL=100 in SET_H, 010 in SET_M, 001 in SET_S, 000 in RUN and COMMIT.
- Field editing, applied only in SET states and only to the selected field:
  - INC press: value+1; 23->0 for hours, 59->0 for minutes and seconds.
  - DEC press: value-1; 0->23 for hours, 0->59 for minutes and seconds.
  - INC and DEC pressed in the same cycle: no change, but the press counts as activity.
  - INC/DEC presses in RUN or COMMIT are ignored.
  - MODE pressed in the same cycle as INC/DEC: the edit applies to the field selected before the transition, and the state still advances.
- Timeout counter:
  - Clears on entry to any SET state and on any accepted key press (MODE, INC or DEC).
  - Otherwise increments each cycle in SET states and saturates.
  - Held at 0 in RUN and COMMIT.
- Blink:
  - The blink counter runs only in SET states.
  - BLINK toggles every BLINK_HALF cycles and starts at 1 on SET entry.
  - Counter and BLINK restart on each state change between SET states.
  - BLINK=0 in RUN and COMMIT.
- Outside RUN->SET_H, H_set/M_set/S_set change only by edits. In RUN they hold their last value and do not track H_cur.
- A key held continuously produces exactly one press event (no auto-repeat).
- Asserting reset mid-edit returns to RUN with no WR pulse; the edit is discarded.
- All registers use RST in their sensitivity; there are no synchronous reset terms.

Test Plan:
(Bench parameters: DEB_CYC=4, TIMEOUT_CYC=64, BLINK_HALF=8.)
1. Reset, then a 3-cycle MODE glitch -> no state change, LOAD=0. A 10-cycle MODE press with H_cur=12, M_cur=34, S_cur=56 -> SET_H, SEL=100, LOAD=1, H_set=12, M_set=34, S_set=56, BLINK=1.
2. In SET_H with H_set=23, press INC -> H_set=0. Press DEC -> H_set=23. Press MODE, set M_set=0, press DEC -> M_set=59, SEL=010.
3. Full sequence MODE x4 from RUN with one INC in SET_S (S_set=56->57) -> exactly one cycle WR=1 with 12/34/57, then RUN, LOAD=0, SEL=000.
4. Enter SET_M, no keys for 64 cycles -> COMMIT (WR pulse) then RUN. Repeat with an INC press every 40 cycles -> no timeout.
5. In SET_S, INC and DEC raw edges aligned -> S_set unchanged and timeout counter cleared. MODE+INC in the same cycle in SET_H -> H_set+1, then SET_M.
6. In SET_M with M_set edited, assert RST=0 asynchronously between clock edges -> outputs go to reset values immediately, no WR pulse. Hold INC for 200 cycles in SET_S -> exactly one increment.
